// File: rtl/coef_stream_rom_pkg.sv
// coef_pkg: shared coefficient width, default series table, sequencer states and table lookup
package coef_pkg;
  localparam int COEF_W = 16;
  localparam int N_DEF = 7;
  localparam logic signed [COEF_W-1:0] COEF_DEF [N_DEF] = '{
    -16'sd1024, -16'sd170, -16'sd68, -16'sd36, -16'sd23, -16'sd16, -16'sd11
  };
  typedef enum logic {IDLE, STREAM} seq_state_e;
  function automatic logic signed [COEF_W-1:0] coef_default(input int idx);
    return (idx >= 0 && idx < N_DEF) ? COEF_DEF[idx[2:0]] : '0;
  endfunction
endpackage

// File: rtl/coef_stream_rom_if.sv
// coef_stream_rom_if: read port, stream handshake and optional COEF_STREAM_ROM_LOAD_EN write port bundle
interface coef_stream_rom_if #(
  parameter int WIDTH = 16,
  parameter int ADDR_W = 4
) ();
  logic rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic rd_valid;
  logic start;
  logic [ADDR_W-1:0] start_term;
  logic [WIDTH-1:0] coef_data;
  logic [ADDR_W-1:0] coef_idx;
  logic coef_valid;
  logic coef_ready;
  logic coef_last;
  logic busy;
  logic done;
  logic err;
`ifdef COEF_STREAM_ROM_LOAD_EN
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  modport slave (
    input rd_en, rd_addr, start, start_term, coef_ready, wr_en, wr_addr, wr_data,
    output rd_data, rd_valid, coef_data, coef_idx, coef_valid, coef_last, busy, done, err
  );
  modport master (
    output rd_en, rd_addr, start, start_term, coef_ready, wr_en, wr_addr, wr_data,
    input rd_data, rd_valid, coef_data, coef_idx, coef_valid, coef_last, busy, done, err
  );
`else
  modport slave (
    input rd_en, rd_addr, start, start_term, coef_ready,
    output rd_data, rd_valid, coef_data, coef_idx, coef_valid, coef_last, busy, done, err
  );
  modport master (
    output rd_en, rd_addr, start, start_term, coef_ready,
    input rd_data, rd_valid, coef_data, coef_idx, coef_valid, coef_last, busy, done, err
  );
`endif
endinterface

// File: rtl/coef_stream_rom_table.sv
// coef_table: coefficient storage with two combinational read ports, writable under COEF_STREAM_ROM_LOAD_EN
module coef_table
  import coef_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
`ifdef COEF_STREAM_ROM_LOAD_EN
  input logic clk,
  input logic rst,
  input logic wr_en,
  input logic [ADDR_W-1:0] wr_addr,
  input logic [WIDTH-1:0] wr_data,
`endif
  input logic [ADDR_W-1:0] ra_addr,
  input logic [ADDR_W-1:0] sa_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] sa_data
);
`ifdef COEF_STREAM_ROM_LOAD_EN
  logic [WIDTH-1:0] tab_q [DEPTH];
  logic [WIDTH-1:0] tab_d [DEPTH];
  always_comb begin
    tab_d = tab_q;
    if (wr_en) tab_d[wr_addr] = wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < DEPTH; i++) tab_q[i] <= WIDTH'(coef_default(i));
    else tab_q <= tab_d;
  end
  assign ra_data = tab_q[ra_addr];
  assign sa_data = tab_q[sa_addr];
`else
  logic [WIDTH-1:0] tab [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign tab[i] = WIDTH'(coef_default(i));
  end
  assign ra_data = tab[ra_addr];
  assign sa_data = tab[sa_addr];
`endif
endmodule

// File: rtl/coef_stream_rom.sv
// coef_stream_rom: coefficient table with registered random read and valid/ready term sequencer (option COEF_STREAM_ROM_LOAD_EN)
module coef_stream_rom
  import coef_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_TERMS = 7
) (
  input logic clk,
  input logic rst,
  coef_stream_rom_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_TERMS - 1);
  seq_state_e state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, sa_addr;
  logic [WIDTH-1:0] data_q, data_d, rd_data_q, rd_data_d, ra_data, sa_data;
  logic last_q, last_d, done_q, done_d, err_q, err_d, rd_valid_q, rd_valid_d;
  logic go, fire, adv;
  coef_table #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_table (
`ifdef COEF_STREAM_ROM_LOAD_EN
    .clk(clk),
    .rst(rst),
    .wr_en(bus.wr_en),
    .wr_addr(bus.wr_addr),
    .wr_data(bus.wr_data),
`endif
    .ra_addr(bus.rd_addr),
    .sa_addr(sa_addr),
    .ra_data(ra_data),
    .sa_data(sa_data)
  );
  always_comb begin
    go = state_q == IDLE && bus.start && bus.start_term <= LAST;
    fire = state_q == STREAM && bus.coef_ready;
    adv = go || (fire && !last_q);
    sa_addr = go ? bus.start_term : idx_q + 1'b1;
    state_d = go ? STREAM : (fire && last_q) ? IDLE : state_q;
    idx_d = go ? bus.start_term : adv ? idx_q + 1'b1 : idx_q;
    data_d = adv ? sa_data : data_q;
    last_d = state_d == STREAM && idx_d == LAST;
    done_d = fire && last_q;
    err_d = state_q == IDLE && bus.start && bus.start_term > LAST;
    rd_data_d = bus.rd_en ? ra_data : rd_data_q;
    rd_valid_d = bus.rd_en;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      data_q <= data_d;
      last_q <= last_d;
      done_q <= done_d;
      err_q <= err_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  assign bus.rd_data = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.coef_data = data_q;
  assign bus.coef_idx = idx_q;
  assign bus.coef_valid = state_q == STREAM;
  assign bus.coef_last = last_q;
  assign bus.busy = state_q == STREAM;
  assign bus.done = done_q;
  assign bus.err = err_q;
endmodule
